// File: rtl/fsm_cpu_pkg.sv
// Shared opcodes, FSM state encoding and parameter checks for the fsm_cpu_core slice.
package fsm_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_IMM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_PAUSE  = 3'd7
  } state_t;

  // The opcode field sits directly above the rd/rs fields, so the word must hold all three.
  function automatic bit width_ok(input int data_w, input int ra_w);
    return data_w >= 4 + 2 * ra_w;
  endfunction

  // Opcodes ADD..LDI write rd and update the zero flag.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/fsm_cpu_alu.sv
// Combinational ALU for fsm_cpu_core; opcodes that compute nothing (NOP, jumps, B-E) yield 0.
module fsm_cpu_alu
  import fsm_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:         result = a + b;
      OP_SUB:         result = a - b;
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_MOV, OP_LDI: result = b;
      OP_INC:         result = a + DATA_W'(1);
      default:        result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/fsm_cpu_core.sv
// Multi-cycle FSM processor core with program RAM, immediates, JZ and single-step debug.
// Optional breakpoint support is built when FSM_CPU_BREAKPOINT_EN is defined.
module fsm_cpu_core
  import fsm_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FSM_CPU_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
`endif
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [2:0]        state_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic              zero_out,
  output logic              halt,
  output logic              busy
);

  localparam int RA_W   = $clog2(NREGS);
  localparam int OP_LSB = 2 * RA_W;
  localparam int DEPTH  = 2 ** PC_W;

  if (!width_ok(DATA_W, RA_W)) begin : g_width_check
    $error("fsm_cpu_core: DATA_W must be at least 4+2*clog2(NREGS)");
  end

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir, imm, alu_result, alu_y;
  logic              zero, alu_zero;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] mem  [DEPTH];

  logic [3:0]        op;
  logic [RA_W-1:0]   rd, rs;
  logic              bp_hit, resume, prog_ok, take_jump;

  assign op = ir[OP_LSB+3:OP_LSB];
  assign rd = ir[OP_LSB-1:RA_W];
  assign rs = ir[RA_W-1:0];

  fsm_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (regs[rd]),
    .b      ((op == OP_LDI) ? imm : regs[rs]),
    .result (alu_y),
    .zero   (alu_zero)
  );

`ifdef FSM_CPU_BREAKPOINT_EN
  // bp_skip lets the resumed fetch at the breakpoint address proceed once.
  logic bp_skip, bp_pause;

  assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
  assign resume = bp_pause ? (step || start) : (step || !step_mode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_skip  <= 1'b0;
      bp_pause <= 1'b0;
    end else if (state == ST_FETCH) begin
      bp_skip  <= bp_hit;
      bp_pause <= bp_hit;
    end else if (state == ST_PAUSE && resume) begin
      bp_pause <= 1'b0;
    end
  end
`else
  assign bp_hit = 1'b0;
  assign resume = step || !step_mode;
`endif

  assign take_jump = (op == OP_JMP) || ((op == OP_JZ) && zero);
  assign prog_ok   = (state == ST_IDLE) || (state == ST_HALT) || (state == ST_PAUSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
      ST_FETCH:         state_nxt = bp_hit ? ST_PAUSE : ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LDI, OP_JMP, OP_JZ: state_nxt = ST_IMM;
          OP_HALT:               state_nxt = ST_HALT;
          default:               state_nxt = ST_EXEC;
        endcase
      end
      ST_IMM:           state_nxt = ST_EXEC;
      ST_EXEC:          state_nxt = ST_WB;
      ST_WB:            state_nxt = step_mode ? ST_PAUSE : ST_FETCH;
      ST_PAUSE:         if (resume) state_nxt = ST_FETCH;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      ir         <= '0;
      imm        <= '0;
      alu_result <= '0;
      zero       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: if (start) pc <= '0;
        ST_FETCH: begin
          if (!bp_hit) begin
            ir <= mem[pc];
            pc <= pc + PC_W'(1);
          end
        end
        ST_IMM: begin
          imm <= mem[pc];
          pc  <= pc + PC_W'(1);
        end
        ST_EXEC: begin
          alu_result <= alu_y;
          if (writes_rd(op)) zero <= alu_zero;
        end
        ST_WB: begin
          if (writes_rd(op)) regs[rd] <= alu_result;
          if (take_jump)     pc <= imm[PC_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: program RAM has no reset so it maps onto plain RAM; contents survive a core reset.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) mem[prog_addr] <= prog_data;
  end

  assign pc_out         = pc;
  assign ir_out         = ir;
  assign state_out      = state;
  assign alu_result_out = alu_result;
  assign zero_out       = zero;
  assign halt           = (state == ST_HALT);
  assign busy           = (state != ST_IDLE) && (state != ST_HALT);

endmodule

// File: tb/tb_fsm_cpu_core.sv
// Scoreboard bench for fsm_cpu_core: an instruction-level interpreter predicts every HALT/PAUSE event.
module tb_fsm_cpu_core;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int PC_W   = 5;

  logic              clk = 1'b0, reset = 1'b1;
  logic              start = 1'b0, step_mode = 1'b0, step = 1'b0, prog_we = 1'b0;
  logic [PC_W-1:0]   prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic [PC_W-1:0]   pc_out;
  logic [DATA_W-1:0] ir_out, alu_result_out;
  logic [2:0]        state_out;
  logic              zero_out, halt, busy;
`ifdef FSM_CPU_BREAKPOINT_EN
  logic              bp_en = 1'b0;
  logic [PC_W-1:0]   bp_addr = '0;
`endif

  always #5 clk = ~clk;

  fsm_cpu_core #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef FSM_CPU_BREAKPOINT_EN
    .bp_en          (bp_en),
    .bp_addr        (bp_addr),
`endif
    .start          (start),
    .step_mode      (step_mode),
    .step           (step),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .pc_out         (pc_out),
    .ir_out         (ir_out),
    .state_out      (state_out),
    .alu_result_out (alu_result_out),
    .zero_out       (zero_out),
    .halt           (halt),
    .busy           (busy)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, run_t0 = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected externally visible event: entry into HALT or PAUSE.
  typedef struct {
    bit         is_halt;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [7:0] alu;
    logic       zero;
    int         cycles;   // -1 when timing depends on step pulses
  } ev_t;

  ev_t exp_q[$];

  // Reference model: architectural state only.
  logic [7:0] m_mem  [32];
  logic [7:0] m_regs [4];
  logic [7:0] m_alu, m_ir;
  logic       m_zero;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_alu  = 8'h00;
    m_ir   = 8'h00;
    m_zero = 1'b0;
  endtask

  task automatic push_ev(input bit is_halt, input logic [4:0] pc, input int cycles);
    ev_t e;
    e.is_halt = is_halt;
    e.pc      = pc;
    e.ir      = m_ir;
    e.alu     = m_alu;
    e.zero    = m_zero;
    e.cycles  = cycles;
    exp_q.push_back(e);
  endtask

  // Interprets the program from address 0 and queues the events a run will produce.
  task automatic model_run(input bit step_m, input int bp, output int n_pause);
    logic [4:0] pc;
    logic [7:0] w, imm, a, b, r;
    logic [3:0] op;
    logic [1:0] rd, rs;
    int         cycles;
    bit         bp_done;
    pc = 5'd0; cycles = 1; n_pause = 0; bp_done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bp >= 0 && !bp_done && pc == 5'(bp)) begin
        bp_done = 1'b1;
        push_ev(1'b0, pc, -1);
        n_pause++;
      end
      w = m_mem[pc]; m_ir = w; pc = pc + 5'd1;
      op = w[7:4]; rd = w[3:2]; rs = w[1:0];
      if (op == 4'hF) begin
        cycles += 2;
        push_ev(1'b1, pc, (step_m || bp >= 0) ? -1 : cycles);
        return;
      end
      imm = 8'h00;
      if (op inside {4'h8, 4'h9, 4'hA}) begin
        imm = m_mem[pc]; pc = pc + 5'd1; cycles += 5;
      end else begin
        cycles += 4;
      end
      a = m_regs[rd];
      b = (op == 4'h8) ? imm : m_regs[rs];
      case (op)
        4'h1:       r = a + b;
        4'h2:       r = a - b;
        4'h3:       r = a & b;
        4'h4:       r = a | b;
        4'h5:       r = a ^ b;
        4'h6, 4'h8: r = b;
        4'h7:       r = a + 8'd1;
        default:    r = 8'h00;
      endcase
      m_alu = r;
      if (op >= 4'h1 && op <= 4'h8) begin
        m_zero    = (r == 8'h00);
        m_regs[rd] = r;
      end
      if (op == 4'h9 || (op == 4'hA && m_zero)) pc = imm[4:0];
      if (step_m) begin
        push_ev(1'b0, pc, -1);
        n_pause++;
      end
    end
    $display("FAIL model_run: program did not halt");
    $fatal(1, "reference model runaway");
  endtask

  // Monitor: compares each HALT/PAUSE entry against the scoreboard head.
  logic [2:0] prev_state = 3'd0;
  ev_t        mon_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_state = 3'd0;
    end else begin
      if (state_out != prev_state && (state_out == 3'd6 || state_out == 3'd7)) begin
        if (exp_q.size() == 0) begin
          check("event_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_state", 32'(state_out), mon_e.is_halt ? 32'd6 : 32'd7);
          check("ev_pc",    32'(pc_out), 32'(mon_e.pc));
          check("ev_ir",    32'(ir_out), 32'(mon_e.ir));
          check("ev_alu",   32'(alu_result_out), 32'(mon_e.alu));
          check("ev_zero",  32'(zero_out), 32'(mon_e.zero));
          check("ev_halt",  32'(halt), 32'(mon_e.is_halt));
          check("ev_busy",  32'(busy), 32'(!mon_e.is_halt));
          if (mon_e.cycles >= 0) check("ev_cycles", 32'(cyc - run_t0), 32'(mon_e.cycles));
        end
      end
      prev_state = state_out;
    end
  end

  task automatic dut_write(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic prog_write(input logic [4:0] a, input logic [7:0] d);
    m_mem[a] = d;
    dut_write(a, d);
  endtask

  task automatic wait_state(input logic [2:0] target, input string name);
    for (int i = 0; i < 500; i++) begin
      if (state_out == target) return;
      @(negedge clk);
    end
    check({"timeout_", name}, 32'(state_out), 32'(target));
  endtask

  // One run from IDLE/HALT to HALT; optional write at a pause and an ignored write while busy.
  task automatic run_prog(input bit step_m, input int bp, input int patch_at,
                          input logic [4:0] patch_addr, input logic [7:0] patch_data,
                          input int busy_addr);
    int n_pause;
    model_run(step_m, bp, n_pause);
    step_mode = step_m;
    start = 1'b1; run_t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (busy_addr >= 0) begin
      @(negedge clk);
      check("busy_in_run", 32'(busy), 32'd1);
      dut_write(5'(busy_addr), 8'h77);
    end
    for (int k = 0; k < n_pause; k++) begin
      wait_state(3'd7, "pause");
      if (k == patch_at) dut_write(patch_addr, patch_data);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    wait_state(3'd6, "halt");
    step_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_test1();
    logic [7:0] p [6];
    p = '{8'h80, 8'h05, 8'h84, 8'h03, 8'h11, 8'hF0};
    for (int i = 0; i < 6; i++) prog_write(5'(i), p[i]);
  endtask

  initial begin
    int         nins, pos, j;
    logic [3:0] op;
    logic [3:0] ops [$];
    int         addr [$];

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_pc",    32'(pc_out), 32'd0);
    check("rst_ir",    32'(ir_out), 32'd0);
    check("rst_alu",   32'(alu_result_out), 32'd0);
    check("rst_zero",  32'(zero_out), 32'd0);
    check("rst_halt",  32'(halt), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 32; i++) prog_write(5'(i), 8'($urandom));

    // Test 1, with a write to the HALT word while busy that must be ignored.
    load_test1();
    run_prog(1'b0, -1, -1, 5'd0, 8'h00, 5);

    // Test 2: JZ taken, then not taken after patching the immediate.
    prog_write(5'd0, 8'h80); prog_write(5'd1, 8'h00); prog_write(5'd2, 8'hA0);
    prog_write(5'd3, 8'h07); prog_write(5'd4, 8'hF0); prog_write(5'd7, 8'hF0);
    run_prog(1'b0, -1, -1, 5'd0, 8'h00, -1);
    prog_write(5'd1, 8'h01);
    run_prog(1'b0, -1, -1, 5'd0, 8'h00, -1);

    // Test 3: single step; ADD at 4 is replaced by SUB while paused just before it.
    load_test1();
    m_mem[4] = 8'h21;
    run_prog(1'b1, -1, 1, 5'd4, 8'h21, -1);

    // Test 4: reset during EXEC of ADD.
    load_test1();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !(state_out == 3'd4 && ir_out == 8'h11); i++) @(negedge clk);
    check("add_exec_reached", 32'(state_out), 32'd4);
    reset = 1'b1;
    #1;
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_pc",    32'(pc_out), 32'd0);
    check("abort_ir",    32'(ir_out), 32'd0);
    check("abort_alu",   32'(alu_result_out), 32'd0);
    check("abort_zero",  32'(zero_out), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    prog_write(5'd0, 8'h60); prog_write(5'd1, 8'hF0);
    run_prog(1'b0, -1, -1, 5'd0, 8'h00, -1);

    // Test 5: jump to the last word, PC wraps to 0.
    prog_write(5'd0, 8'h90); prog_write(5'd1, 8'h1F);
    prog_write(5'd30, 8'h00); prog_write(5'd31, 8'hF0);
    run_prog(1'b0, -1, -1, 5'd0, 8'h00, -1);

`ifdef FSM_CPU_BREAKPOINT_EN
    // Test 6: breakpoint before the ADD.
    load_test1();
    bp_en = 1'b1; bp_addr = 5'd4;
    run_prog(1'b0, 4, -1, 5'd0, 8'h00, -1);
    bp_en = 1'b0;
`endif

    // Random programs: targets are always later instruction starts, so every run halts.
    for (int t = 0; t < 16; t++) begin
      ops.delete(); addr.delete();
      nins = $urandom_range(4, 10);
      pos  = 0;
      for (int i = 0; i < nins; i++) begin
        op = 4'($urandom_range(0, 14));
        ops.push_back(op);
        addr.push_back(pos);
        pos += (op inside {4'h8, 4'h9, 4'hA}) ? 2 : 1;
      end
      addr.push_back(pos);
      for (int i = 0; i < nins; i++) begin
        prog_write(5'(addr[i]), {ops[i], 4'($urandom)});
        if (ops[i] == 4'h8) begin
          prog_write(5'(addr[i] + 1), 8'($urandom));
        end else if (ops[i] inside {4'h9, 4'hA}) begin
          j = $urandom_range(i + 1, nins);
          prog_write(5'(addr[i] + 1), {3'($urandom), 5'(addr[j])});
        end
      end
      prog_write(5'(addr[nins]), {4'hF, 4'($urandom)});
      run_prog(t[0], -1, -1, 5'd0, 8'h00, -1);
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
